// File: rtl/spaceship_angle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spaceship_angle_ctrl
// Purpose  : Turns two raw rotate buttons into a 16-position sprite angle.
//            Each button is synchronised and debounced; a tap gives one step
//            on the next frame tick, and a held button auto-repeats after an
//            initial delay. Angle only ever moves on a frame tick.
// Ports    : clk           - single clock, rising edge
//            rst_n         - asynchronous active-low reset
//            btn_left      - raw button, active high (rotate -1)
//            btn_right     - raw button, active high (rotate +1)
//            frame_tick    - one-cycle pulse at vblank start
//            angle         - registered rotation index 0..15
//            angle_changed - one-cycle pulse in the cycle angle updates
// Revision : 1.0 - initial release
// ============================================================================
module spaceship_angle_ctrl #(
    parameter int DEBOUNCE_CYCLES     = 125000,
    parameter int REPEAT_DELAY_FRAMES = 20,
    parameter int REPEAT_RATE_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    output logic [3:0] angle,
    output logic       angle_changed
);

    localparam int c_db_w    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int c_fr_max  = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                               REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int c_fr_w    = $clog2(c_fr_max) + 1;

    localparam logic [c_db_w-1:0] c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_fr_w-1:0] c_fr_delay = c_fr_w'(REPEAT_DELAY_FRAMES);
    localparam logic [c_fr_w-1:0] c_fr_rate  = c_fr_w'(REPEAT_RATE_FRAMES);
    localparam logic [c_fr_w-1:0] c_fr_one   = c_fr_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_DELAY   = 2'd2,
        ST_REPEAT  = 2'd3
    } state_t;

    // Bit 0 is the left button, bit 1 the right button throughout.
    logic [1:0]        sync1_q, sync1_d;
    logic [1:0]        sync2_q, sync2_d;
    logic [1:0]        db_q, db_d;
    logic [c_db_w-1:0] db_cnt_q [2];
    logic [c_db_w-1:0] db_cnt_d [2];

    state_t            state_q, state_d;
    logic              dir_q, dir_d;          // 1 = right, 0 = left
    logic [c_fr_w-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]        angle_q, angle_d;
    logic              angle_changed_q, angle_changed_d;

    logic              w_eff_left;
    logic              w_eff_right;
    logic              w_eff_match;
    logic              w_step;

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = {btn_right, btn_left};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                // Accept the new level on the cycle the count reaches the
                // limit, and restart so a quick reversal is debounced afresh.
                if (db_cnt_q[i] == c_db_last) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Both buttons held cancel each other out.
    assign w_eff_left  = db_q[0] & ~db_q[1];
    assign w_eff_right = db_q[1] & ~db_q[0];
    assign w_eff_match = dir_q ? w_eff_right : w_eff_left;

    // ------------------------------------------------------------------
    // Step / auto-repeat state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        frame_cnt_d = frame_cnt_q;
        w_step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A coincident frame tick is deliberately ignored here.
                if (w_eff_left || w_eff_right) begin
                    dir_d   = w_eff_right;
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Button state is not consulted: a short tap still steps.
                if (frame_tick) begin
                    w_step      = 1'b1;
                    frame_cnt_d = c_fr_delay;
                    state_d     = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!w_eff_match) begin
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    if (frame_cnt_q <= c_fr_one) begin
                        w_step      = 1'b1;
                        frame_cnt_d = c_fr_rate;
                        state_d     = ST_REPEAT;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // 4-bit arithmetic gives the 15<->0 wrap for free.
    always_comb begin
        angle_d         = angle_q;
        angle_changed_d = w_step;
        if (w_step) begin
            angle_d = dir_q ? (angle_q + 4'd1) : (angle_q - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            db_q            <= '0;
            db_cnt_q[0]     <= '0;
            db_cnt_q[1]     <= '0;
            state_q         <= ST_IDLE;
            dir_q           <= 1'b1;
            frame_cnt_q     <= '0;
            angle_q         <= '0;
            angle_changed_q <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            db_q            <= db_d;
            db_cnt_q[0]     <= db_cnt_d[0];
            db_cnt_q[1]     <= db_cnt_d[1];
            state_q         <= state_d;
            dir_q           <= dir_d;
            frame_cnt_q     <= frame_cnt_d;
            angle_q         <= angle_d;
            angle_changed_q <= angle_changed_d;
        end
    end

    assign angle         = angle_q;
    assign angle_changed = angle_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_spaceship_angle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spaceship_angle_ctrl
// Purpose  : Self-checking bench for spaceship_angle_ctrl. A behavioural
//            model tracks the expected angle every cycle; directed scenarios
//            (tap, bounce, hold with wrap, both buttons, tick coincidence,
//            reset mid-repeat) add explicit end-point checks, followed by a
//            randomised button sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spaceship_angle_ctrl;

    localparam int c_db    = 4;
    localparam int c_dly   = 3;
    localparam int c_rate  = 2;
    localparam int c_frame = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_left;
    logic       btn_right;
    logic       frame_tick;
    logic [3:0] angle;
    logic       angle_changed;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulse_cnt;
    int pulse_vals[$];

    // Reference model state. Index 0 = left, 1 = right.
    bit m_s1[2];
    bit m_s2[2];
    bit m_db[2];
    int m_cnt[2];
    int m_mode;      // 0 idle, 1 waiting for first tick, 2 held
    int m_dir;       // +1 right, -1 left
    int m_ticks;     // frame ticks seen since the first step
    int m_angle;
    int m_changed;

    spaceship_angle_ctrl #(
        .DEBOUNCE_CYCLES     (c_db),
        .REPEAT_DELAY_FRAMES (c_dly),
        .REPEAT_RATE_FRAMES  (c_rate)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .frame_tick    (frame_tick),
        .angle         (angle),
        .angle_changed (angle_changed)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_cnt[i] = 0;
        end
        m_mode = 0; m_dir = 1; m_ticks = 0; m_angle = 0; m_changed = 0;
    endtask

    task automatic model_step();
        m_angle   = (m_angle + m_dir + 16) % 16;
        m_changed = 1;
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        int eff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        eff = (m_db[0] && !m_db[1]) ? -1 : ((m_db[1] && !m_db[0]) ? 1 : 0);
        m_changed = 0;
        case (m_mode)
            0: if (eff != 0) begin m_dir = eff; m_mode = 1; end
            1: if (frame_tick) begin model_step(); m_mode = 2; m_ticks = 0; end
            default: begin
                if (eff != m_dir) begin
                    m_mode = 0;
                end else if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks >= c_dly && ((m_ticks - c_dly) % c_rate) == 0)
                        model_step();
                end
            end
        endcase
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == c_db) begin
                    m_db[i]  = m_s2[i];
                    m_cnt[i] = 0;
                end
            end else begin
                m_cnt[i] = 0;
            end
            m_s2[i] = m_s1[i];
        end
        m_s1[0] = btn_left;
        m_s1[1] = btn_right;
    endtask

    task automatic step_clk();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle_angle", 32'(angle), m_angle);
        check("cycle_changed", 32'(angle_changed), m_changed);
        if (angle_changed === 1'b1) begin
            pulse_cnt++;
            pulse_vals.push_back(int'(angle));
        end
        cyc++;
        frame_tick = ((cyc % c_frame) == c_frame - 1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    // Advance until cyc % frame == p (edge index k with k % frame == p-1).
    task automatic wait_phase(input int p);
        int guard;
        guard = 0;
        while ((cyc % c_frame) != p && guard < 2 * c_frame) begin
            step_clk();
            guard++;
        end
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_angle", 32'(angle), 0);
        check("async_reset_changed", 32'(angle_changed), 0);
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_hold[5];
        int got;
        exp_hold = '{15, 14, 13, 12, 11};
        rst_n = 1'b0; btn_left = 1'b0; btn_right = 1'b0; frame_tick = 1'b0;
        pulse_cnt = 0;
        model_reset();
        #1;
        check("reset_angle", 32'(angle), 0);
        check("reset_changed", 32'(angle_changed), 0);
        run(3);
        rst_n = 1'b1;

        // Tap: one step only.
        pulse_cnt = 0;
        btn_right = 1'b1; run(8);
        btn_right = 1'b0; run(60);
        check("tap_pulses", pulse_cnt, 1);
        check("tap_angle", 32'(angle), 1);

        // Bounce: never accepted.
        do_reset();
        pulse_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            btn_left = ((i / 2) % 2) == 0;
            step_clk();
        end
        btn_left = 1'b0; run(40);
        check("bounce_pulses", pulse_cnt, 0);
        check("bounce_angle", 32'(angle), 0);

        // Hold left with wrap: steps on ticks 1,4,6,8,10.
        do_reset();
        wait_phase(1);
        pulse_cnt = 0; pulse_vals.delete();
        btn_left = 1'b1; run(200);
        btn_left = 1'b0; run(30);
        check("hold_pulses", pulse_cnt, 5);
        for (int i = 0; i < 5; i++) begin
            got = (i < pulse_vals.size()) ? pulse_vals[i] : -1;
            check("hold_step_value", got, exp_hold[i]);
        end

        // Both buttons: cancel, then a fresh first step when left releases.
        wait_phase(1);
        btn_right = 1'b1; run(25);
        check("both_first_step", 32'(angle), 12);
        pulse_cnt = 0;
        btn_left = 1'b1; run(75);
        check("both_held_pulses", pulse_cnt, 0);
        check("both_held_angle", 32'(angle), 12);
        pulse_cnt = 0;
        btn_left = 1'b0; run(25);
        check("both_release_pulses", pulse_cnt, 1);
        check("both_release_angle", 32'(angle), 13);
        btn_right = 1'b0; run(40);

        // Debounced edge coincides with a frame tick: step waits a frame.
        wait_phase(13);
        pulse_cnt = 0;
        btn_left = 1'b1; run(8);
        check("coinc_no_step", pulse_cnt, 0);
        check("coinc_angle_hold", 32'(angle), 13);
        run(20);
        btn_left = 1'b0;
        check("coinc_step_pulses", pulse_cnt, 1);
        check("coinc_step_angle", 32'(angle), 12);
        run(40);

        // Reset during repeat with angle 7, button kept held.
        do_reset();
        wait_phase(1);
        btn_right = 1'b1; run(290);
        check("pre_reset_angle", 32'(angle), 7);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step_clk();
            check("post_reset_hold", 32'(angle), 0);
        end
        run(25);
        check("post_reset_step", 32'(angle), 1);
        btn_right = 1'b0; run(40);

        // Randomised button activity with occasional resets.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            run($urandom_range(1, 45));
        end
        btn_left = 1'b0; btn_right = 1'b0; run(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
